// File: rtl/dram_stream_engine.sv
// DRAM stream engine: streams N consecutive lines to the memory request queue,
// either writing a seeded pattern or reading it back and checking it.
// Reports a checksum, a mismatch count and elapsed cycles once the stream ends.
module dram_stream_engine #(
    parameter int unsigned ADDR_W          = 64,
    parameter int unsigned DATA_W          = 512,
    parameter int unsigned LINE_BYTES      = 64,
    parameter int unsigned MAX_OUTSTANDING = 64
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_is_write,
    input  logic [ADDR_W-1:0] cmd_base_addr,
    input  logic [31:0]       cmd_num_lines,
    input  logic [31:0]       cmd_seed,

    output logic              mem_req_valid,
    output logic              mem_req_is_write,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_data,
    input  logic              mem_req_grant,

    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic              mem_resp_grant,

    output logic              done_pulse,
    output logic [31:0]       done_checksum,
    output logic [31:0]       done_mismatches,
    output logic [31:0]       done_cycles,
    output logic              spurious
);

    localparam int unsigned WORDS = DATA_W / 32;
    // Wide enough to hold MAX_OUTSTANDING up to 512.
    localparam int unsigned OUT_W = 10;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } state_t;

    state_t            stateQ, stateD;

    // Latched command fields
    logic              isWriteQ;
    logic [31:0]       numLinesQ;

    // Request-side progress: next address and pattern word track issuedQ
    logic [31:0]       issuedQ;
    logic [ADDR_W-1:0] reqAddrQ;
    logic [31:0]       reqWordQ;

    // Response-side progress: expected pattern word tracks receivedQ
    logic [31:0]       receivedQ;
    logic [31:0]       expWordQ;
    logic [OUT_W-1:0]  outstandingQ;

    // Results
    logic [31:0]       checksumQ;
    logic [31:0]       mismatchesQ;
    logic [31:0]       cyclesQ;
    logic              spuriousQ;

    // Decoded per-cycle events
    logic              active;
    logic              readActive;
    logic              cmdAccept;
    logic              reqValid;
    logic              reqFire;
    logic              readGrant;
    logic              lastGrant;
    logic              respAccept;
    logic              respDrop;
    logic              respMismatch;
    logic [31:0]       respSum;
    logic [31:0]       receivedNext;

    // Decode handshakes and stream status from registered state.
    always_comb begin
        active       = (stateQ == StIssue) || (stateQ == StDrain);
        readActive   = active && !isWriteQ;
        cmdAccept    = cmd_valid && (stateQ == StIdle);
        reqValid     = (stateQ == StIssue) &&
                       (isWriteQ || (outstandingQ < OUT_W'(MAX_OUTSTANDING)));
        reqFire      = reqValid && mem_req_grant;
        readGrant    = reqFire && !isWriteQ;
        lastGrant    = reqFire && (issuedQ == (numLinesQ - 32'd1));
        // A response with nothing outstanding cannot belong to this stream.
        respAccept   = mem_resp_valid && readActive && (outstandingQ != '0);
        respDrop     = mem_resp_valid && !respAccept;
        respMismatch = (mem_resp_data != {WORDS{expWordQ}});
        receivedNext = receivedQ + {31'd0, respAccept};
    end

    // Sum of all 32-bit words in the incoming response line.
    always_comb begin
        respSum = '0;
        for (int unsigned i = 0; i < WORDS; i++) begin
            respSum = respSum + mem_resp_data[i*32 +: 32];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state logic.
    always_comb begin
        stateD = stateQ;
        case (stateQ)
            StIdle: begin
                if (cmd_valid) begin
                    stateD = (cmd_num_lines == 32'd0) ? StDone : StIssue;
                end
            end
            StIssue: begin
                if (lastGrant) begin
                    if (isWriteQ || (receivedNext == numLinesQ)) begin
                        stateD = StDone;
                    end else begin
                        stateD = StDrain;
                    end
                end
            end
            StDrain: begin
                if (receivedNext == numLinesQ) begin
                    stateD = StDone;
                end
            end
            StDone: begin
                stateD = StIdle;
            end
            default: begin
                stateD = StIdle;
            end
        endcase
    end

    // Latch the command fields on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            isWriteQ  <= 1'b0;
            numLinesQ <= '0;
        end else if (cmdAccept) begin
            isWriteQ  <= cmd_is_write;
            numLinesQ <= cmd_num_lines;
        end
    end

    // Request pointer: address and pattern word advance on each granted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            issuedQ  <= '0;
            reqAddrQ <= '0;
            reqWordQ <= '0;
        end else if (cmdAccept) begin
            issuedQ  <= '0;
            reqAddrQ <= cmd_base_addr;
            reqWordQ <= cmd_seed;
        end else if (reqFire) begin
            issuedQ  <= issuedQ + 32'd1;
            reqAddrQ <= reqAddrQ + ADDR_W'(LINE_BYTES);
            reqWordQ <= reqWordQ + 32'd1;
        end
    end

    // Response accounting: checksum, mismatches and received count.
    always_ff @(posedge clk) begin
        if (rst) begin
            receivedQ   <= '0;
            expWordQ    <= '0;
            checksumQ   <= '0;
            mismatchesQ <= '0;
        end else if (cmdAccept) begin
            receivedQ   <= '0;
            expWordQ    <= cmd_seed;
            checksumQ   <= '0;
            mismatchesQ <= '0;
        end else if (respAccept) begin
            receivedQ   <= receivedNext;
            expWordQ    <= expWordQ + 32'd1;
            checksumQ   <= checksumQ + respSum;
            if (respMismatch) begin
                mismatchesQ <= mismatchesQ + 32'd1;
            end
        end
    end

    // Outstanding reads: a grant and a response in the same cycle cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstandingQ <= '0;
        end else if (cmdAccept) begin
            outstandingQ <= '0;
        end else if (readGrant && !respAccept) begin
            outstandingQ <= outstandingQ + OUT_W'(1);
        end else if (!readGrant && respAccept) begin
            outstandingQ <= outstandingQ - OUT_W'(1);
        end
    end

    // Saturating busy-cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyclesQ <= '0;
        end else if (cmdAccept) begin
            cyclesQ <= '0;
        end else if (active && (cyclesQ != '1)) begin
            cyclesQ <= cyclesQ + 32'd1;
        end
    end

    // Sticky flag for responses consumed outside a read stream; a response
    // dropped in the accept cycle still counts against the new command.
    always_ff @(posedge clk) begin
        if (rst) begin
            spuriousQ <= 1'b0;
        end else if (cmdAccept) begin
            spuriousQ <= respDrop;
        end else if (respDrop) begin
            spuriousQ <= 1'b1;
        end
    end

    // Outputs depend only on registered state, except the always-consume grant.
    always_comb begin
        cmd_ready        = (stateQ == StIdle);
        mem_req_valid    = reqValid;
        mem_req_is_write = isWriteQ;
        mem_req_addr     = reqAddrQ;
        mem_req_data     = {WORDS{reqWordQ}};
        mem_resp_grant   = mem_resp_valid;
        done_pulse       = (stateQ == StDone);
        done_checksum    = checksumQ;
        done_mismatches  = mismatchesQ;
        done_cycles      = cyclesQ;
        spurious         = spuriousQ;
    end

endmodule

// File: tb/tb_dram_stream_engine.sv
// Scoreboard bench for dram_stream_engine: the stimulus pushes expected requests
// and completions into queues, a monitor pops and compares them, and a memory
// model answers reads in order one cycle after the grant.
module tb_dram_stream_engine;

    logic         clk;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_is_write;
    logic [63:0]  cmd_base_addr;
    logic [31:0]  cmd_num_lines;
    logic [31:0]  cmd_seed;
    logic         mem_req_valid;
    logic         mem_req_is_write;
    logic [63:0]  mem_req_addr;
    logic [511:0] mem_req_data;
    logic         mem_req_grant;
    logic         mem_resp_valid;
    logic [511:0] mem_resp_data;
    logic         mem_resp_grant;
    logic         done_pulse;
    logic [31:0]  done_checksum;
    logic [31:0]  done_mismatches;
    logic [31:0]  done_cycles;
    logic         spurious;

    dram_stream_engine dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_is_write    (cmd_is_write),
        .cmd_base_addr   (cmd_base_addr),
        .cmd_num_lines   (cmd_num_lines),
        .cmd_seed        (cmd_seed),
        .mem_req_valid   (mem_req_valid),
        .mem_req_is_write(mem_req_is_write),
        .mem_req_addr    (mem_req_addr),
        .mem_req_data    (mem_req_data),
        .mem_req_grant   (mem_req_grant),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_data   (mem_resp_data),
        .mem_resp_grant  (mem_resp_grant),
        .done_pulse      (done_pulse),
        .done_checksum   (done_checksum),
        .done_mismatches (done_mismatches),
        .done_cycles     (done_cycles),
        .spurious        (spurious)
    );

    typedef struct {
        logic        isWrite;
        logic [63:0] addr;
        logic [31:0] word;
    } reqExp_t;

    typedef struct {
        logic [31:0] sum;
        logic [31:0] mis;
        logic [31:0] cyc;
        logic        chkCyc;
    } doneExp_t;

    reqExp_t  expReq[$];
    doneExp_t expDone[$];

    // Memory model state
    logic [511:0] memory [logic [63:0]];
    logic [511:0] respQ[$];
    logic [511:0] line;
    int           readIdx;
    int           readGrantCnt;
    int           corruptIdx;
    int           grantLimit;
    int           relCredit;
    logic         grantOn;
    logic         holdResp;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    // Returns at negedge+3 once the engine is idle, or flags a timeout.
    task automatic waitIdle(input int budget);
        int c;
        c = 0;
        @(negedge clk);
        #3;
        while (!cmd_ready && c < budget) begin
            @(negedge clk);
            #3;
            c++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout actual busy required idle within %0d cycles", budget);
        end
    endtask

    task automatic issueCmd(input logic w, input logic [63:0] base, input logic [31:0] n,
                            input logic [31:0] seed, input int nExp, input logic doneExp,
                            input logic [31:0] eSum, input logic [31:0] eMis,
                            input logic [31:0] eCyc, input logic chkCyc);
        waitIdle(300);
        for (int i = 0; i < nExp; i++) begin
            expReq.push_back('{w, base + 64'(i) * 64'd64, seed + 32'(i)});
        end
        if (doneExp) expDone.push_back('{eSum, eMis, eCyc, chkCyc});
        readIdx       = 0;
        readGrantCnt  = 0;
        cmd_valid     = 1'b1;
        cmd_is_write  = w;
        cmd_base_addr = base;
        cmd_num_lines = n;
        cmd_seed      = seed;
        @(negedge clk);
        cmd_valid = 1'b0;
        #3;
    endtask

    // Memory model: grants requests, stores writes, queues read data in order.
    initial begin
        mem_req_grant  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        forever begin
            @(negedge clk);
            mem_req_grant = grantOn && (grantLimit < 0 || readGrantCnt < grantLimit);
            if (respQ.size() > 0 && (!holdResp || relCredit > 0)) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = respQ[0];
            end else begin
                mem_resp_valid = 1'b0;
                mem_resp_data  = '0;
            end
            #1;
            if (mem_req_valid && mem_req_grant) begin
                if (mem_req_is_write) begin
                    memory[mem_req_addr] = mem_req_data;
                end else begin
                    line = memory.exists(mem_req_addr) ? memory[mem_req_addr] : '0;
                    if (readIdx == corruptIdx) line[0] = ~line[0];
                    respQ.push_back(line);
                    readIdx++;
                    readGrantCnt++;
                end
            end
            if (mem_resp_valid) begin
                void'(respQ.pop_front());
                if (holdResp && relCredit > 0) relCredit--;
            end
        end
    end

    // Monitor: compares every granted request and every completion strobe.
    initial begin
        reqExp_t  er;
        doneExp_t ed;
        int       bad;
        forever begin
            @(negedge clk);
            #2;
            if (mem_req_valid && mem_req_grant) begin
                if (expReq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL req_unexpected actual addr %0h required no request",
                             mem_req_addr);
                end else begin
                    er = expReq.pop_front();
                    chk("req_kind", 64'(mem_req_is_write), 64'(er.isWrite));
                    chk("req_addr", mem_req_addr, er.addr);
                    bad = 0;
                    for (int w = 0; w < 16; w++) begin
                        if (mem_req_data[w*32 +: 32] !== er.word) bad = w;
                    end
                    chk("req_data", 64'(mem_req_data[bad*32 +: 32]), 64'(er.word));
                end
            end
            if (done_pulse) begin
                if (expDone.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected actual pulse required none");
                end else begin
                    ed = expDone.pop_front();
                    chk("done_checksum", 64'(done_checksum), 64'(ed.sum));
                    chk("done_mismatches", 64'(done_mismatches), 64'(ed.mis));
                    if (ed.chkCyc) chk("done_cycles", 64'(done_cycles), 64'(ed.cyc));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual running required finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        rst           = 1'b1;
        cmd_valid     = 1'b0;
        cmd_is_write  = 1'b0;
        cmd_base_addr = '0;
        cmd_num_lines = '0;
        cmd_seed      = '0;
        grantOn       = 1'b1;
        grantLimit    = -1;
        holdResp      = 1'b0;
        relCredit     = 0;
        corruptIdx    = -1;
        readIdx       = 0;
        readGrantCnt  = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #3;

        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_done_pulse", 64'(done_pulse), 64'd0);
        chk("rst_checksum", 64'(done_checksum), 64'd0);
        chk("rst_mismatches", 64'(done_mismatches), 64'd0);
        chk("rst_cycles", 64'(done_cycles), 64'd0);
        chk("rst_spurious", 64'(spurious), 64'd0);

        // 4-line write, then read it back: words 0xA..0xD, 16 each -> 0x2E0
        issueCmd(1'b1, 64'h1000, 32'd4, 32'hA, 4, 1'b1, 32'h0, 32'd0, 32'd4, 1'b1);
        issueCmd(1'b0, 64'h1000, 32'd4, 32'hA, 4, 1'b1, 32'h2E0, 32'd0, 32'd5, 1'b1);
        waitIdle(100);
        chk("readback_spurious", 64'(spurious), 64'd0);

        // 100-line region, then read with responses withheld
        issueCmd(1'b1, 64'h20000, 32'd100, 32'h100, 100, 1'b1, 32'h0, 32'd0, 32'd100, 1'b1);
        holdResp = 1'b1;
        issueCmd(1'b0, 64'h20000, 32'd100, 32'h100, 100, 1'b1, 32'h77560, 32'd0, 32'd0,
                 1'b0);
        repeat (80) @(negedge clk);
        #3;
        chk("hold_grants", 64'(readGrantCnt), 64'd64);
        chk("hold_req_valid", 64'(mem_req_valid), 64'd0);
        relCredit = 1;
        repeat (5) @(negedge clk);
        #3;
        chk("release1_grants", 64'(readGrantCnt), 64'd65);
        chk("release1_req_valid", 64'(mem_req_valid), 64'd0);
        holdResp = 1'b0;
        waitIdle(1000);

        // Zero-length command completes immediately
        issueCmd(1'b0, 64'h5000, 32'd0, 32'h1, 0, 1'b1, 32'h0, 32'd0, 32'd0, 1'b1);
        chk("zero_done_pulse", 64'(done_pulse), 64'd1);
        chk("zero_req_valid", 64'(mem_req_valid), 64'd0);
        chk("zero_cycles", 64'(done_cycles), 64'd0);

        // Address wrap, then read back with response 1 corrupted:
        // 16*0x55 + (16*0x56 + 1) = 0x550 + 0x561 = 0xAB1
        issueCmd(1'b1, 64'hFFFF_FFFF_FFFF_FFC0, 32'd2, 32'h55, 2, 1'b1, 32'h0, 32'd0, 32'd2,
                 1'b1);
        corruptIdx = 1;
        issueCmd(1'b0, 64'hFFFF_FFFF_FFFF_FFC0, 32'd2, 32'h55, 2, 1'b1, 32'hAB1, 32'd1, 32'd3,
                 1'b1);
        waitIdle(100);
        corruptIdx = -1;

        // Reset with 10 reads outstanding
        holdResp   = 1'b1;
        grantLimit = 10;
        issueCmd(1'b0, 64'h1000, 32'd20, 32'hA, 10, 1'b0, 32'h0, 32'd0, 32'd0, 1'b0);
        repeat (15) @(negedge clk);
        #3;
        chk("pre_rst_grants", 64'(readGrantCnt), 64'd10);
        rst = 1'b1;
        @(negedge clk);
        #3;
        rst = 1'b0;
        chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("mid_rst_req_valid", 64'(mem_req_valid), 64'd0);
        chk("mid_rst_spurious", 64'(spurious), 64'd0);
        grantLimit = -1;
        holdResp   = 1'b0;
        c = 0;
        while (respQ.size() > 0 && c < 50) begin
            @(negedge clk);
            c++;
        end
        repeat (2) @(negedge clk);
        #3;
        chk("late_resp_left", 64'(respQ.size()), 64'd0);
        chk("late_resp_spurious", 64'(spurious), 64'd1);
        issueCmd(1'b1, 64'h6000, 32'd0, 32'h0, 0, 1'b1, 32'h0, 32'd0, 32'd0, 1'b1);
        chk("accept_clears_spurious", 64'(spurious), 64'd0);

        waitIdle(100);
        chk("expreq_left", 64'(expReq.size()), 64'd0);
        chk("expdone_left", 64'(expDone.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dram_stream_engine.md
Name: dram_stream_engine

Overview:
- Command-driven DRAM traffic engine sitting directly upstream of the simplified memory interface (MemReq / MemResp request and response queues).
- Accepts one command at a time: stream N consecutive 64-byte lines either written with a seeded pattern or read back and checked.
- Reports a checksum, mismatch count and elapsed cycles for bandwidth measurement and thermal-load generation.

Parameters:
ADDR_W, 64, memory address width
DATA_W, 512, line data width (16 x 32-bit words)
LINE_BYTES, 64, address increment per line
MAX_OUTSTANDING, 64, maximum read requests granted but not yet answered (must be <= 512)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  engine idle; command accepted when cmd_valid && cmd_ready
cmd_is_write  in  1  1 = write stream, 0 = read/verify stream
cmd_base_addr  in  ADDR_W  first line address
cmd_num_lines  in  32  number of lines
cmd_seed  in  32  pattern seed
mem_req_valid  out  1  request valid
mem_req_is_write  out  1  request type
mem_req_addr  out  ADDR_W  request address
mem_req_data  out  DATA_W  write data
mem_req_grant  in  1  request accepted this cycle
mem_resp_valid  in  1  read response present
mem_resp_data  in  DATA_W  read data
mem_resp_grant  out  1  response consumed this cycle
done_pulse  out  1  one-cycle completion strobe
done_checksum  out  32  sum mod 2^32 of all 32-bit words read (0 for writes)
done_mismatches  out  32  read lines differing from expected pattern
done_cycles  out  32  cycles from ISSUE entry to DONE, saturating
spurious  out  1  sticky: response consumed while no read stream active

Behaviour:
- Reset values: state IDLE, cmd_ready 1, mem_req_valid 0, done_pulse 0, all counters, checksum, mismatches, cycles and spurious 0.
- States:
  - IDLE: cmd_ready = 1. On accept, latch all cmd fields and clear issue/response counters, checksum, mismatches, cycles and spurious. If num_lines == 0, go to DONE; else go to ISSUE.
  - ISSUE: mem_req_valid = is_write || (outstanding < MAX_OUTSTANDING).
    - mem_req_addr = base + issued*LINE_BYTES, wrapping mod 2^ADDR_W.
    - mem_req_data = cmd_seed + issued, replicated 16 times.
    - A grant with valid increments issued. A grant is ignored when valid is 0.
    - When the last line is granted: writes go to DONE; reads go to DRAIN.
  - DRAIN: wait until received == num_lines, then go to DONE. If the last response arrives in the same cycle as the last grant, go directly to DONE.
  - DONE: done_pulse = 1 for exactly one cycle, then IDLE. done_* outputs hold their values until the next accept.
- Request path: mem_req_valid, mem_req_addr and mem_req_data depend only on registered state, never on mem_req_grant. First request is valid the cycle after accept.
- Response path:
  - mem_resp_grant = mem_resp_valid (always consume).
  - Responses return in request order.
  - For read response k: checksum += sum of its 16 words; mismatches += 1 if data != replicate(seed + k); received += 1.
  - A response consumed in IDLE, DONE or a write stream is dropped and sets spurious.
- outstanding counter:
  - +1 on a granted read request; -1 on a consumed read response; unchanged when both occur in the same cycle.
  - Never exceeds MAX_OUTSTANDING and never underflows.
- done_cycles increments every cycle in ISSUE/DRAIN and saturates at 0xFFFFFFFF. It is 0 for num_lines == 0.
- cmd_valid while busy is ignored (cmd_ready = 0); the command is not queued.
- Reset mid-operation: immediate return to IDLE with all state cleared. Late responses after reset are consumed and set spurious.

Test Plan:
- Write, base 0x1000, 4 lines, seed 0xA, grant held 1 -> addresses 0x1000/0x1040/0x1080/0x10C0 on consecutive cycles, data words 0xA..0xD, done_pulse once, checksum 0, mismatches 0.
- Read-back of the same region, model returns the written data -> done_checksum 0x2E0, done_mismatches 0, spurious 0.
- Read 100 lines, model withholds responses -> exactly 64 grants then mem_req_valid 0; each released response admits exactly one more request; done after 100 responses.
- num_lines 0 -> done_pulse the cycle after accept, no mem_req_valid, done_cycles 0.
- Base 0xFFFF_FFFF_FFFF_FFC0, 2-line write -> second address 0x0. Read with response 1 corrupted -> mismatches 1.
- rst asserted mid-read with 10 outstanding -> next cycle cmd_ready 1, mem_req_valid 0. A later response sets spurious; the next accept clears it.
